// File: rtl/otter_div_unit_if.sv
// ----------------------------------------------------------------------------
// otter_div_unit_if
//   Handshake and operand bundle between the OTTER execute stage and the
//   iterative divide/remainder unit.
//
//   START   launch request (accepted only while the unit is idle)
//   FLUSH   abort any in-flight operation
//   FUNCT3  func3[1:0]: 00 div, 01 divu, 10 rem, 11 remu
//   SRC_A   dividend
//   SRC_B   divisor
//   BUSY    operation iterating
//   DONE    one-cycle pulse, RESULT valid
//   RESULT  quotient or remainder, held until the next completed operation
//
//   master: execute stage / hazard unit side (drives requests)
//   slave : divide unit side
// ----------------------------------------------------------------------------
interface otter_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic             FLUSH;
    logic [1:0]       FUNCT3;
    logic [WIDTH-1:0] SRC_A;
    logic [WIDTH-1:0] SRC_B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;

    modport master (
        output START, FLUSH, FUNCT3, SRC_A, SRC_B,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, FLUSH, FUNCT3, SRC_A, SRC_B,
        output BUSY, DONE, RESULT
    );
endinterface

// File: rtl/otter_div_unit.sv
// ----------------------------------------------------------------------------
// otter_div_unit
//   Iterative RV32M divide/remainder unit sitting beside the ALU. Restoring
//   shift-subtract on operand magnitudes, one quotient bit per cycle; signs
//   are fixed up when the result is written. Division by zero and signed
//   MIN_INT / -1 bypass the iteration and finish one cycle after START.
//
//   Ports:
//     CLK  clock, all state changes on the rising edge
//     RST  synchronous active-high reset (clears state and datapath)
//     dif  otter_div_unit_if.slave: START/FLUSH/FUNCT3/SRC_A/SRC_B in,
//          BUSY/DONE/RESULT out
//
//   Latency (START sampled at edge 0): DONE in cycle WIDTH+1 on the normal
//   path, cycle 1 on the special path.
// ----------------------------------------------------------------------------
module otter_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    otter_div_unit_if.slave  dif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] count;
    logic             op_rem;       // latched FUNCT3[1]: remainder requested
    logic             neg_q;        // quotient must be negated
    logic             neg_r;        // remainder must be negated
    logic [WIDTH-1:0] divisor;      // |divisor|
    logic [WIDTH-1:0] quo;          // dividend magnitude shifting out, quotient in
    logic [WIDTH-1:0] rem;          // partial remainder
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_prev;  // value to restore if FIN is flushed

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    // ---- launch decode (operands as presented in IDLE) ----
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic [WIDTH-1:0] special_res;
    logic             accept;

    assign in_signed = ~dif.FUNCT3[0];
    assign a_neg     = in_signed & dif.SRC_A[WIDTH-1];
    assign b_neg     = in_signed & dif.SRC_B[WIDTH-1];
    assign a_mag     = apply_sign(dif.SRC_A, a_neg);
    assign b_mag     = apply_sign(dif.SRC_B, b_neg);
    assign div_zero  = (dif.SRC_B == '0);
    assign overflow  = in_signed && (dif.SRC_A == MIN_INT) && (dif.SRC_B == '1);
    assign special   = div_zero | overflow;
    // x/0: quotient all-ones, remainder = dividend.
    // MIN_INT/-1: quotient = MIN_INT (the dividend itself), remainder 0.
    assign special_res = div_zero ? (dif.FUNCT3[1] ? dif.SRC_A : '1)
                                  : (dif.FUNCT3[1] ? '0 : dif.SRC_A);
    assign accept    = (state == ST_IDLE) && dif.START && !dif.FLUSH;

    // ---- one restoring iteration ----
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             last_iter;
    logic [WIDTH-1:0] final_res;

    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, divisor};
    assign fits      = ~diff[WIDTH];
    // Either branch is below the divisor, so the top bit is always zero here.
    assign rem_nxt   = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nxt   = {quo[WIDTH-2:0], fits};
    assign last_iter = (count == CNT_W'(WIDTH - 1));
    assign final_res = op_rem ? apply_sign(rem_nxt, neg_r) : apply_sign(quo_nxt, neg_q);

    // ---- state register ----
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept) state_nxt = special ? ST_FIN : ST_RUN;
            ST_RUN: begin
                if (dif.FLUSH)      state_nxt = ST_IDLE;
                else if (last_iter) state_nxt = ST_FIN;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- outputs ----
    always_comb begin
        dif.BUSY   = (state == ST_RUN);
        dif.DONE   = (state == ST_FIN) && !dif.FLUSH;
        dif.RESULT = result;
    end

    // ---- datapath ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            count       <= '0;
            op_rem      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            divisor     <= '0;
            quo         <= '0;
            rem         <= '0;
            result      <= '0;
            result_prev <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_rem  <= dif.FUNCT3[1];
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        divisor <= b_mag;
                        quo     <= a_mag;
                        rem     <= '0;
                        count   <= '0;
                        if (special) begin
                            result_prev <= result;
                            result      <= special_res;
                        end
                    end
                end
                ST_RUN: begin
                    if (!dif.FLUSH) begin
                        rem   <= rem_nxt;
                        quo   <= quo_nxt;
                        count <= count + 1'b1;
                        if (last_iter) begin
                            result_prev <= result;
                            result      <= final_res;
                        end
                    end
                end
                ST_FIN: begin
                    // A flush in the DONE cycle cancels the op: roll RESULT back.
                    if (dif.FLUSH) result <= result_prev;
                end
                default: ;
            endcase
        end
    end

endmodule
